cond_logic: RTL

//  Receiving end of the decode unit's control outputs in the multicycle ARM core.

---
 rtl/cond_logic.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//   Condition unit for the multicycle ARM core. It holds the NZCV status
//   register, evaluates each instruction's condition field once per
//   instruction (in the decode cycle), and gates decode's raw write requests
//   into the datapath enables.
//
//   Optional feature: define COND_STATS_EN to add the ExecCount/SquashCount
//   statistics counters and ports. Without it, the counters and ports are
//   absent and everything else behaves the same.
//
// Parameters
//   CNT_W      width of the statistics counters (COND_STATS_EN only)
//   FLAGS_RST  NZCV value loaded on reset
//
// Ports
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   Cond         instruction condition field (Instr[31:28])
//   ALUFlags     live {N,Z,C,V} from the ALU
//   FlagW        [1] write N,Z  [0] write C,V
//   PCS          PC-changing write requested by decode
//   NextPC       unconditional PC+4 write (fetch)
//   RegW/MemW    register-file / memory write requested by decode
//   IRWrite      instruction register loads this cycle
//   PCWrite      datapath PC enable
//   RegWrite     datapath register-file enable
//   MemWrite     datapath memory write enable
//   Flags        stored {N,Z,C,V}
//   CondEx       registered condition result of the current instruction
//   ExecCount    instructions whose condition passed (COND_STATS_EN)
//   SquashCount  instructions whose condition failed (COND_STATS_EN)
// ---------------------------------------------------------------------------
module cond_logic #(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t state;
  logic   cond_pass;
  logic   en;

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = Flags;

  // Condition evaluation always uses the stored flags, never the live ALU flags.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      default: cond_pass = 1'b1;  // 1110 AL and 1111 unconditional
    endcase
  end

  // Write requests only reach the datapath in the execute phase of an
  // instruction whose condition passed. The reset term keeps NextPC from
  // leaking through while reset is held.
  assign en       = (state == S_EXEC) & CondEx;
  assign PCWrite  = reset & (NextPC | (PCS & en));
  assign RegWrite = reset & RegW & en;
  assign MemWrite = reset & MemW & en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_WAIT;
      Flags  <= FLAGS_RST;
      CondEx <= 1'b0;
    end else begin
      if (en) begin
        if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      end
      case (state)
        S_WAIT: begin
          if (IRWrite) state <= S_DECODE;
        end
        S_DECODE: begin
          // IRWrite is deliberately ignored here: decode always advances.
          CondEx <= cond_pass;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          if (IRWrite) state <= S_DECODE;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

`ifdef COND_STATS_EN
  // One counter steps per decode cycle; both stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ExecCount   <= '0;
      SquashCount <= '0;
    end else if (state == S_DECODE) begin
      if (cond_pass) begin
        if (ExecCount != '1) ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        if (SquashCount != '1) SquashCount <= SquashCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule
